// File: rtl/conv_sequencer.sv
// conv_sequencer: control sequencer for a KxK convolution over a WxW feature map.
// Walks output pixels in raster order and, per pixel, K*K kernel taps, then
// presents the pixel to downstream and clears the accumulator.
module conv_sequencer #(
  parameter int W = 28,
  parameter int K = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       acc_enable,
  output logic       flush_acc,
  output logic [4:0] i,
  output logic [4:0] j,
  output logic [2:0] ki,
  output logic [2:0] kj,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_EMIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last valid output-pixel coordinate and last valid kernel-tap index.
  localparam logic [4:0] LAST_POS = 5'(W - K);
  localparam logic [2:0] LAST_TAP = 3'(K - 1);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] i_nxt;
  logic [4:0] j_nxt;
  logic [2:0] ki_nxt;
  logic [2:0] kj_nxt;

  logic last_tap;
  logic last_col;
  logic last_pix;

  assign last_tap = (ki == LAST_TAP) && (kj == LAST_TAP);
  assign last_col = (j == LAST_POS);
  assign last_pix = (i == LAST_POS) && last_col;

  // State and counter registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      ki    <= '0;
      kj    <= '0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
      j     <= j_nxt;
      ki    <= ki_nxt;
      kj    <= kj_nxt;
    end
  end

  // Next-state and counter update: taps advance only on accepted sums,
  // pixel coordinates advance only when the accumulator is flushed.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    ki_nxt    = ki;
    kj_nxt    = kj;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ACCUM;
          i_nxt     = '0;
          j_nxt     = '0;
          ki_nxt    = '0;
          kj_nxt    = '0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          if (last_tap) begin
            state_nxt = S_EMIT;
            ki_nxt    = '0;
            kj_nxt    = '0;
          end else if (kj == LAST_TAP) begin
            kj_nxt = '0;
            ki_nxt = ki + 3'd1;
          end else begin
            kj_nxt = kj + 3'd1;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (last_pix) begin
          state_nxt = S_DONE;
          i_nxt     = '0;
          j_nxt     = '0;
        end else if (last_col) begin
          state_nxt = S_ACCUM;
          j_nxt     = '0;
          i_nxt     = i + 5'd1;
        end else begin
          state_nxt = S_ACCUM;
          j_nxt     = j + 5'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        i_nxt     = '0;
        j_nxt     = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        i_nxt     = '0;
        j_nxt     = '0;
        ki_nxt    = '0;
        kj_nxt    = '0;
      end
    endcase
  end

  // Output decode from the registered state; acc_enable also gates on in_valid
  // so a stalled tap never reaches the accumulator.
  always_comb begin
    acc_enable = (state == S_ACCUM) && in_valid;
    flush_acc  = (state == S_FLUSH);
    out_valid  = (state == S_EMIT);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed checks of the convolution sequencer at W=28, K=3.
module tb_conv_sequencer;

  localparam int W = 28;
  localparam int K = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic       acc_enable;
  logic       flush_acc;
  logic [4:0] i;
  logic [4:0] j;
  logic [2:0] ki;
  logic [2:0] kj;
  logic       out_valid;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  // Event counters maintained by the monitor below.
  int cyc         = 0;
  int overlap_cnt = 0;
  int range_cnt   = 0;
  int hs_cnt      = 0;
  int hs_prev     = 0;
  int hs_last     = 0;
  int flush_cnt   = 0;
  int flush_last  = 0;
  int done_cnt    = 0;
  int done_last   = 0;
  int busy_cnt    = 0;
  int acc_cnt     = 0;

  conv_sequencer #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .acc_enable(acc_enable),
    .flush_acc (flush_acc),
    .i         (i),
    .j         (j),
    .ki        (ki),
    .kj        (kj),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor of handshakes, pulses and illegal combinations.
  always @(negedge clk) begin
    if (acc_enable && flush_acc) overlap_cnt++;
    if (out_valid && !(!acc_enable && !flush_acc && busy)) overlap_cnt++;
    if (i > 5'(W - K) || j > 5'(W - K) || ki > 3'(K - 1) || kj > 3'(K - 1)) range_cnt++;
    if (out_valid && out_ready) begin
      hs_cnt++;
      hs_prev = hs_last;
      hs_last = cyc;
    end
    if (flush_acc) begin
      flush_cnt++;
      flush_last = cyc;
    end
    if (done) begin
      done_cnt++;
      done_last = cyc;
    end
    if (busy) busy_cnt++;
    if (acc_enable) acc_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_acc"}, 32'(acc_enable), 32'd0);
    chk({tag, "_flush"}, 32'(flush_acc), 32'd0);
    chk({tag, "_ovld"}, 32'(out_valid), 32'd0);
    chk({tag, "_i"}, 32'(i), 32'd0);
    chk({tag, "_j"}, 32'(j), 32'd0);
    chk({tag, "_ki"}, 32'(ki), 32'd0);
    chk({tag, "_kj"}, 32'(kj), 32'd0);
  endtask

  // Runs with in_valid=1, handshaking every pixel until pixel (ti,tj) sits in EMIT.
  task automatic goto_pixel(input int ti, input int tj);
    int n;
    n = 0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!(out_valid && i == 5'(ti) && j == 5'(tj)) && n < 5000) begin
      out_ready = out_valid;
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("goto_timeout", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int a0;
    int hs0;
    int fl0;
    int dn0;
    int bz0;
    int n;

    // Reset with every other input active: reset must win.
    rst       = 1'b1;
    start     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_idle("idle_hold");

    // Pixel (0,0) with in_valid alternating 0,1: 18 cycles to EMIT, 9 accumulations.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    a0 = acc_cnt;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c % 2 == 1);
      #1;
      chk("stall_ki", 32'(ki), 32'((c / 2) / 3));
      chk("stall_kj", 32'(kj), 32'((c / 2) % 3));
      chk("stall_acc", 32'(acc_enable), 32'(c % 2));
      tick();
    end
    in_valid = 1'b0;
    chk("stall_emit", 32'(out_valid), 32'd1);
    chk("stall_i", 32'(i), 32'd0);
    chk("stall_j", 32'(j), 32'd0);
    chk("stall_taps_reset", 32'({ki, kj}), 32'd0);
    chk("stall_acc_total", 32'(acc_cnt - a0), 32'd9);
    out_ready = 1'b1;
    tick();
    chk("p00_flush", 32'(flush_acc), 32'd1);
    chk("p00_flush_ovld", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("p01_i", 32'(i), 32'd0);
    chk("p01_j", 32'(j), 32'd1);
    chk("p01_flush_off", 32'(flush_acc), 32'd0);

    // Column wrap at the end of row 0.
    goto_pixel(0, 25);
    out_ready = 1'b1;
    tick();
    chk("wrap_flush", 32'(flush_acc), 32'd1);
    out_ready = 1'b0;
    tick();
    chk("wrap_i", 32'(i), 32'd1);
    chk("wrap_j", 32'(j), 32'd0);
    chk("wrap_accum", 32'({out_valid, busy}), 32'd1);

    // Downstream backpressure in EMIT at pixel (3,7).
    goto_pixel(3, 7);
    for (int c = 0; c < 5; c++) begin
      chk("bp_ovld", 32'(out_valid), 32'd1);
      chk("bp_i", 32'(i), 32'd3);
      chk("bp_j", 32'(j), 32'd7);
      chk("bp_flush", 32'(flush_acc), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_flush_after", 32'(flush_acc), 32'd1);
    chk("bp_flush_i", 32'(i), 32'd3);
    chk("bp_flush_j", 32'(j), 32'd7);
    out_ready = 1'b0;
    tick();
    chk("bp_next_i", 32'(i), 32'd3);
    chk("bp_next_j", 32'(j), 32'd8);
    chk("bp_next_ovld", 32'(out_valid), 32'd0);

    // Reset mid-ACCUM at pixel (10,4), tap 5.
    goto_pixel(10, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    repeat (5) tick();
    chk("mid_i", 32'(i), 32'd10);
    chk("mid_j", 32'(j), 32'd4);
    chk("mid_ki", 32'(ki), 32'd1);
    chk("mid_kj", 32'(kj), 32'd2);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk_idle("midrst");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk_idle("midrst_hold");
    start = 1'b1;
    tick();
    start = 1'b0;
    a0 = acc_cnt;
    repeat (9) tick();
    chk("restart_emit", 32'(out_valid), 32'd1);
    chk("restart_i", 32'(i), 32'd0);
    chk("restart_j", 32'(j), 32'd0);
    chk("restart_acc", 32'(acc_cnt - a0), 32'd9);

    // Full pass with free-flowing data and repeated start pulses while busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a0  = acc_cnt;
    hs0 = hs_cnt;
    fl0 = flush_cnt;
    dn0 = done_cnt;
    bz0 = busy_cnt;
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 8000) begin
      start = (n % 4 == 1);
      tick();
      n++;
    end
    start = 1'b0;
    chk("pass_timeout", 32'(n < 8000), 32'd1);
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_done_i", 32'(i), 32'd0);
    chk("pass_done_j", 32'(j), 32'd0);
    tick();
    chk("pass_idle_busy", 32'(busy), 32'd0);
    chk("pass_idle_done", 32'(done), 32'd0);
    repeat (3) tick();
    chk("pass_no_restart", 32'(busy), 32'd0);
    chk("pass_handshakes", 32'(hs_cnt - hs0), 32'd676);
    chk("pass_flushes", 32'(flush_cnt - fl0), 32'd676);
    chk("pass_acc", 32'(acc_cnt - a0), 32'd6084);
    chk("pass_busy_cycles", 32'(busy_cnt - bz0), 32'd7437);
    chk("pass_done_pulses", 32'(done_cnt - dn0), 32'd1);
    chk("pass_period", 32'(hs_last - hs_prev), 32'd11);
    chk("pass_done_after_flush", 32'(done_last - flush_last), 32'd1);
    chk("no_acc_flush_overlap", 32'(overlap_cnt), 32'd0);
    chk("counter_range", 32'(range_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
